// File: rtl/fifo.sv
// ---------------------------------------------------------------------------
// fifo: generic synchronous element FIFO with valid/ready handshakes.
//
// First-word-fall-through: the head element is driven combinationally on
// elem_out_o whenever the FIFO holds data. Supports any DEPTH >= 2, including
// non-power-of-two depths; pointers wrap explicitly at DEPTH-1.
//
// Optional feature (compile-time macro FIFO_BYPASS_EN):
//   When defined, an element offered while the FIFO is empty is forwarded
//   combinationally to the output in the same cycle. If the consumer takes it
//   in that cycle it is never written; otherwise it is stored normally.
//   When undefined, the minimum latency is one cycle and there is no
//   combinational input-to-output path.
//
// Parameters:
//   ELEM_WIDTH  width of one stored element (>= 1)
//   DEPTH       number of storage entries (>= 2)
//
// Ports:
//   clk_i             clock, rising-edge active
//   arst_ni           asynchronous active-low reset
//   elem_in_i         element to push
//   elem_in_valid_i   push request
//   elem_in_ready_o   FIFO can accept (not full)
//   elem_out_o        head element
//   elem_out_valid_o  head element valid (not empty)
//   elem_out_ready_i  consumer accepts the head element
//   el_cnt_o          registered occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module fifo #(
  parameter int unsigned ELEM_WIDTH = 8,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                       clk_i,
  input  logic                       arst_ni,
  input  logic [ELEM_WIDTH-1:0]      elem_in_i,
  input  logic                       elem_in_valid_i,
  output logic                       elem_in_ready_o,
  output logic [ELEM_WIDTH-1:0]      elem_out_o,
  output logic                       elem_out_valid_o,
  input  logic                       elem_out_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] el_cnt_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  localparam logic [PtrW-1:0] PtrLast = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  logic [ELEM_WIDTH-1:0] mem_q [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q,    cnt_d;

  logic full;
  logic empty;
  logic bypass;
  logic push;
  logic pop;

  // Modulo-DEPTH increment; explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    if (ptr == PtrLast) begin
      return '0;
    end
    return ptr + PtrW'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Flags, handshakes and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    full  = (cnt_q == CntFull);
    empty = (cnt_q == '0);

`ifdef FIFO_BYPASS_EN
    bypass = empty && elem_in_valid_i;
`else
    bypass = 1'b0;
`endif

    // Ready depends only on occupancy, never on elem_out_ready_i.
    elem_in_ready_o  = !full;
    elem_out_valid_o = !empty || bypass;
    elem_out_o       = bypass ? elem_in_i : mem_q[rd_ptr_q];

    // A bypassed element consumed in the same cycle never touches storage;
    // pop only counts stored elements.
    push = elem_in_valid_i && !full && !(bypass && elem_out_ready_i);
    pop  = !empty && elem_out_ready_i;

    el_cnt_o = cnt_q;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;

    if (push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is cleared on reset so elem_out_o reads zero after reset.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= elem_in_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  a_cnt_bounded : assert property (@(posedge clk_i) disable iff (!arst_ni)
    cnt_q <= CntFull);

  a_no_push_when_full : assert property (@(posedge clk_i) disable iff (!arst_ni)
    full |-> !push);

  a_wr_ptr_range : assert property (@(posedge clk_i) disable iff (!arst_ni)
    wr_ptr_q <= PtrLast);

  a_rd_ptr_range : assert property (@(posedge clk_i) disable iff (!arst_ni)
    rd_ptr_q <= PtrLast);

endmodule

// File: tb/tb_fifo.sv
// ---------------------------------------------------------------------------
// tb_fifo: self-checking bench for fifo. Two instances share clock and reset:
// a DEPTH=4 instance for the main scenarios and a DEPTH=3 instance for the
// non-power-of-two case. A queue per instance models the expected contents;
// every cycle the occupancy, flags and head element are compared against it.
// ---------------------------------------------------------------------------
module tb_fifo;

  logic clk;
  logic arst_n;

  // DEPTH=4 instance
  logic [7:0] a_in;
  logic       a_in_valid;
  logic       a_in_ready;
  logic [7:0] a_out;
  logic       a_out_valid;
  logic       a_out_ready;
  logic [2:0] a_cnt;

  // DEPTH=3 instance
  logic [7:0] b_in;
  logic       b_in_valid;
  logic       b_in_ready;
  logic [7:0] b_out;
  logic       b_out_valid;
  logic       b_out_ready;
  logic [1:0] b_cnt;

  logic [7:0] q4[$];
  logic [7:0] q3[$];

  int errors = 0;
  int checks = 0;

  fifo #(.ELEM_WIDTH(8), .DEPTH(4)) u_dut4 (
    .clk_i            (clk),
    .arst_ni          (arst_n),
    .elem_in_i        (a_in),
    .elem_in_valid_i  (a_in_valid),
    .elem_in_ready_o  (a_in_ready),
    .elem_out_o       (a_out),
    .elem_out_valid_o (a_out_valid),
    .elem_out_ready_i (a_out_ready),
    .el_cnt_o         (a_cnt)
  );

  fifo #(.ELEM_WIDTH(8), .DEPTH(3)) u_dut3 (
    .clk_i            (clk),
    .arst_ni          (arst_n),
    .elem_in_i        (b_in),
    .elem_in_valid_i  (b_in_valid),
    .elem_in_ready_o  (b_in_ready),
    .elem_out_o       (b_out),
    .elem_out_valid_o (b_out_valid),
    .elem_out_ready_i (b_out_ready),
    .el_cnt_o         (b_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One cycle on the DEPTH=4 instance. Called just after a rising edge.
  task automatic step4(input logic v, input logic [7:0] d, input logic r, input string tag);
    logic do_pop;
    logic do_push;
    a_in_valid  = v;
    a_in        = d;
    a_out_ready = r;
    @(negedge clk);
    checks++;
    if (a_cnt !== 3'(q4.size())) begin
      errors++;
      $display("FAIL %s cnt4: got %0d want %0d", tag, a_cnt, q4.size());
    end
    checks++;
    if (a_in_ready !== (q4.size() != 4)) begin
      errors++;
      $display("FAIL %s in_ready4: got %b want %b", tag, a_in_ready, q4.size() != 4);
    end
    checks++;
    if (a_out_valid !== (q4.size() != 0)) begin
      errors++;
      $display("FAIL %s out_valid4: got %b want %b", tag, a_out_valid, q4.size() != 0);
    end
    if (q4.size() != 0) begin
      checks++;
      if (a_out !== q4[0]) begin
        errors++;
        $display("FAIL %s head4: got %02h want %02h", tag, a_out, q4[0]);
      end
    end
    do_pop  = r && (q4.size() != 0);
    do_push = v && (q4.size() != 4);
    if (do_pop) void'(q4.pop_front());
    if (do_push) q4.push_back(d);
    @(posedge clk);
    #1;
  endtask

  // One cycle on the DEPTH=3 instance. Called just after a rising edge.
  task automatic step3(input logic v, input logic [7:0] d, input logic r, input string tag);
    logic do_pop;
    logic do_push;
    b_in_valid  = v;
    b_in        = d;
    b_out_ready = r;
    @(negedge clk);
    checks++;
    if (b_cnt !== 2'(q3.size()) || b_cnt > 2'd3) begin
      errors++;
      $display("FAIL %s cnt3: got %0d want %0d", tag, b_cnt, q3.size());
    end
    checks++;
    if (b_in_ready !== (q3.size() != 3)) begin
      errors++;
      $display("FAIL %s in_ready3: got %b want %b", tag, b_in_ready, q3.size() != 3);
    end
    checks++;
    if (b_out_valid !== (q3.size() != 0)) begin
      errors++;
      $display("FAIL %s out_valid3: got %b want %b", tag, b_out_valid, q3.size() != 0);
    end
    if (q3.size() != 0) begin
      checks++;
      if (b_out !== q3[0]) begin
        errors++;
        $display("FAIL %s head3: got %02h want %02h", tag, b_out, q3[0]);
      end
    end
    do_pop  = r && (q3.size() != 0);
    do_push = v && (q3.size() != 3);
    if (do_pop) void'(q3.pop_front());
    if (do_push) q3.push_back(d);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    arst_n      = 1'b0;
    a_in        = 8'h00;
    a_in_valid  = 1'b0;
    a_out_ready = 1'b0;
    b_in        = 8'h00;
    b_in_valid  = 1'b0;
    b_out_ready = 1'b0;
    #12;
    checks++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_cnt !== 3'd0 || a_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_held: got rdy=%b vld=%b cnt=%0d out=%02h want 1 0 0 00",
               a_in_ready, a_out_valid, a_cnt, a_out);
    end
    @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (a_out !== 8'h00 || b_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_out: got %02h/%02h want 00/00", a_out, b_out);
    end
    step4(1'b0, 8'h00, 1'b0, "idle");
    step3(1'b0, 8'h00, 1'b0, "idle3");
  endtask

  task automatic test_fill();
    step4(1'b1, 8'h11, 1'b0, "fill1");
    step4(1'b1, 8'h22, 1'b0, "fill2");
    step4(1'b1, 8'h33, 1'b0, "fill3");
    step4(1'b1, 8'h44, 1'b0, "fill4");
    // Full: this push must be ignored.
    step4(1'b1, 8'h55, 1'b0, "fill5");
    checks++;
    if (a_out !== 8'h11 || a_cnt !== 3'd4 || a_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_state: got out=%02h cnt=%0d rdy=%b want 11 4 0",
               a_out, a_cnt, a_in_ready);
    end
    // Full with a pop in the same cycle: push still ignored.
    step4(1'b1, 8'h66, 1'b1, "full_pop");
    step4(1'b1, 8'h77, 1'b0, "refill");
  endtask

  task automatic test_drain();
    for (int i = 0; i < 4; i++) step4(1'b0, 8'h00, 1'b1, "drain");
    step4(1'b0, 8'h00, 1'b1, "drained");
    checks++;
    if (a_out_valid !== 1'b0 || a_cnt !== 3'd0) begin
      errors++;
      $display("FAIL empty_after_drain: got vld=%b cnt=%0d want 0 0", a_out_valid, a_cnt);
    end
  endtask

  task automatic test_back_to_back();
    step4(1'b1, 8'hE0, 1'b0, "b2b_pre0");
    step4(1'b1, 8'hE1, 1'b0, "b2b_pre1");
    for (int i = 0; i < 10; i++) step4(1'b1, 8'(i), 1'b1, "b2b");
    checks++;
    if (a_cnt !== 3'd2) begin
      errors++;
      $display("FAIL b2b_count: got %0d want 2", a_cnt);
    end
    step4(1'b0, 8'h00, 1'b1, "b2b_drain");
    step4(1'b0, 8'h00, 1'b1, "b2b_drain");
    step4(1'b0, 8'h00, 1'b0, "b2b_empty");
  endtask

  task automatic test_depth3();
    int sent = 0;
    int cyc  = 0;
    logic v;
    logic r;
    while ((sent < 7 || q3.size() != 0) && cyc < 300) begin
      v = (sent < 7) && ($urandom_range(0, 1) == 1);
      r = ($urandom_range(0, 2) != 0) || (cyc > 200);
      if (v && q3.size() != 3) begin
        step3(1'b1, 8'h30 + 8'(sent), r, "d3");
        sent++;
      end else begin
        step3(v, 8'h30 + 8'(sent), r, "d3");
      end
      cyc++;
    end
    checks++;
    if (sent != 7 || q3.size() != 0) begin
      errors++;
      $display("FAIL d3_complete: got sent=%0d left=%0d want 7 0", sent, q3.size());
    end
    step3(1'b0, 8'h00, 1'b0, "d3_empty");
  endtask

  task automatic test_async_reset();
    step4(1'b1, 8'hB1, 1'b0, "ar1");
    step4(1'b1, 8'hB2, 1'b0, "ar2");
    step4(1'b1, 8'hB3, 1'b0, "ar3");
    a_in_valid = 1'b0;
    // Assert reset mid-cycle; check before the next clock edge.
    #2;
    arst_n = 1'b0;
    #1;
    checks++;
    if (a_out_valid !== 1'b0 || a_cnt !== 3'd0 || a_in_ready !== 1'b1 || a_out !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: got vld=%b cnt=%0d rdy=%b out=%02h want 0 0 1 00",
               a_out_valid, a_cnt, a_in_ready, a_out);
    end
    q4.delete();
    q3.delete();
    #1;
    arst_n = 1'b1;
    @(posedge clk);
    #1;
    step4(1'b1, 8'hA5, 1'b0, "post_push");
    checks++;
    if (a_out_valid !== 1'b1 || a_out !== 8'hA5) begin
      errors++;
      $display("FAIL post_reset_push: got vld=%b out=%02h want 1 a5", a_out_valid, a_out);
    end
    step4(1'b0, 8'h00, 1'b1, "post_pop");
    step4(1'b0, 8'h00, 1'b0, "post_empty");
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_depth3();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
